// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: control, PWM stream and decoded-code signals of the PWM decoder.
interface pwm_decoder_if #(parameter int UDW = 4);
    logic           re;
    logic           ce;
    logic           pwm_in;
    logic [UDW-1:0] code_out;
    logic           code_vld;
    logic           err;
    logic           lock;
    modport master (output re, ce, pwm_in, input code_out, code_vld, err, lock);
    modport slave  (input re, ce, pwm_in, output code_out, code_vld, err, lock);
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers UDW-bit codes from a frame-based PWM stream, aligning frames to rising edges.
module pwm_decoder #(
    parameter int UDW = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    pwm_decoder_if.slave bus
);
    logic [UDW-1:0] ph_q, ph_d, code_q, code_d;
    logic [UDW:0]   hcnt_q, hcnt_d, f;
    logic           prev_q, prev_d, vld_q, vld_d, err_q, err_d, lock_q, lock_d;
    logic           b, rise;
    assign b    = bus.pwm_in;
    assign rise = b & ~prev_q;
    // f reaches 2**UDW only for an all-high frame, so its MSB flags saturation
    assign f    = hcnt_q + (UDW+1)'(b);
    always_comb begin
        ph_d   = ph_q;
        hcnt_d = hcnt_q;
        prev_d = prev_q;
        code_d = code_q;
        lock_d = lock_q;
        vld_d  = 1'b0;
        err_d  = 1'b0;
        if (bus.re) begin
            ph_d   = '0;
            hcnt_d = '0;
            prev_d = 1'b0;
            lock_d = 1'b0;
        end else if (bus.ce) begin
            prev_d = b;
            if (rise && ph_q != '0) begin
                ph_d   = UDW'(1);
                hcnt_d = (UDW+1)'(1);
                err_d  = 1'b1;
                lock_d = 1'b0;
            end else if (&ph_q) begin
                ph_d   = '0;
                hcnt_d = '0;
                vld_d  = 1'b1;
                err_d  = f[UDW];
                lock_d = ~f[UDW];
                code_d = f[UDW] ? '1 : f[UDW-1:0];
            end else begin
                ph_d   = ph_q + UDW'(1);
                hcnt_d = f;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q   <= '0;
            hcnt_q <= '0;
            prev_q <= 1'b0;
            code_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            hcnt_q <= hcnt_d;
            prev_q <= prev_d;
            code_q <= code_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            lock_q <= lock_d;
        end
    end
    assign bus.code_out = code_q;
    assign bus.code_vld = vld_q;
    assign bus.err      = err_q;
    assign bus.lock     = lock_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: table-driven and directed checks of pwm_decoder with UDW=4 (16-tick frames).
module tb_pwm_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int bad = 0;
    int nvld = 0;
    int nerr = 0;
    always #5 clk = ~clk;
    pwm_decoder_if #(.UDW(4)) bus();
    pwm_decoder #(.UDW(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    typedef struct {
        int  code;
        bit  ce_tog;
        int  exp_code;
        int  exp_vld;
        int  exp_err;
        int  exp_lock;
    } vec_t;
    vec_t vecs[5];
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic b, input logic c);
        bus.re = r;
        bus.pwm_in = b;
        bus.ce = c;
        @(posedge clk);
        #1;
        if (bus.code_vld) nvld++;
        if (bus.err) nerr++;
    endtask
    // one 16-tick frame of code k; bad counts any strobe off the last tick
    task automatic frame(input int k, input bit tog);
        for (int t = 0; t < 16; t++) begin
            step(1'b0, t < k, 1'b1);
            if (bus.code_vld !== (t == 15)) bad++;
            if (tog) begin
                step(1'b0, t < k, 1'b0);
                if (bus.code_vld !== 1'b0) bad++;
            end
        end
    endtask
    initial begin
        vecs[0] = '{code: 0,  ce_tog: 1'b0, exp_code: 0,  exp_vld: 3, exp_err: 0, exp_lock: 1};
        vecs[1] = '{code: 1,  ce_tog: 1'b0, exp_code: 1,  exp_vld: 3, exp_err: 0, exp_lock: 1};
        vecs[2] = '{code: 7,  ce_tog: 1'b0, exp_code: 7,  exp_vld: 3, exp_err: 0, exp_lock: 1};
        vecs[3] = '{code: 15, ce_tog: 1'b0, exp_code: 15, exp_vld: 3, exp_err: 0, exp_lock: 1};
        vecs[4] = '{code: 3,  ce_tog: 1'b1, exp_code: 3,  exp_vld: 3, exp_err: 0, exp_lock: 1};
        bus.re = 1'b0;
        bus.ce = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code", int'(bus.code_out), 0);
        chk("rst_vld", int'(bus.code_vld), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_lock", int'(bus.lock), 0);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            step(1'b1, 1'b0, 1'b1);
            nvld = 0;
            nerr = 0;
            bad = 0;
            for (int f = 0; f < 3; f++) frame(vecs[i].code, vecs[i].ce_tog);
            chk($sformatf("v%0d_code", i), int'(bus.code_out), vecs[i].exp_code);
            chk($sformatf("v%0d_nvld", i), nvld, vecs[i].exp_vld);
            chk($sformatf("v%0d_nerr", i), nerr, vecs[i].exp_err);
            chk($sformatf("v%0d_lock", i), int'(bus.lock), vecs[i].exp_lock);
            chk($sformatf("v%0d_vld_timing", i), bad, 0);
        end
        // code 5 starting at phase 9 after re-acquire
        step(1'b1, 1'b0, 1'b1);
        repeat (9) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("mis_err", int'(bus.err), 1);
        chk("mis_lock", int'(bus.lock), 0);
        bad = 0;
        for (int t = 1; t < 16; t++) begin
            step(1'b0, t < 5, 1'b1);
            if (t < 15 && bus.code_vld !== 1'b0) bad++;
        end
        chk("mis_early_vld", bad, 0);
        chk("mis_vld", int'(bus.code_vld), 1);
        chk("mis_code", int'(bus.code_out), 5);
        chk("mis_lock2", int'(bus.lock), 1);
        chk("mis_err2", int'(bus.err), 0);
        // all-high frame saturates and flags error
        step(1'b1, 1'b0, 1'b1);
        repeat (16) step(1'b0, 1'b1, 1'b1);
        chk("hi_code", int'(bus.code_out), 15);
        chk("hi_vld", int'(bus.code_vld), 1);
        chk("hi_err", int'(bus.err), 1);
        chk("hi_lock", int'(bus.lock), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("hi_vld_pulse", int'(bus.code_vld), 0);
        // glitch at phase 10 while locked on code 6
        step(1'b1, 1'b0, 1'b1);
        frame(6, 1'b0);
        frame(6, 1'b0);
        chk("gl_lock_pre", int'(bus.lock), 1);
        chk("gl_code_pre", int'(bus.code_out), 6);
        for (int t = 0; t < 11; t++) step(1'b0, (t < 6) || (t == 10), 1'b1);
        chk("gl_err", int'(bus.err), 1);
        chk("gl_lock", int'(bus.lock), 0);
        nvld = 0;
        repeat (5) step(1'b0, 1'b0, 1'b1);
        chk("gl_no_vld", nvld, 0);
        step(1'b1, 1'b0, 1'b1);
        frame(6, 1'b0);
        chk("gl_relock", int'(bus.lock), 1);
        for (int t = 0; t < 8; t++) step(1'b0, t < 6, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("re_lock", int'(bus.lock), 0);
        chk("re_code", int'(bus.code_out), 6);
        nvld = 0;
        bad = 0;
        frame(6, 1'b0);
        chk("re_relock", int'(bus.lock), 1);
        chk("re_code2", int'(bus.code_out), 6);
        chk("re_vld_timing", bad, 0);
        // asynchronous reset between clock edges
        for (int t = 0; t < 5; t++) step(1'b0, t < 6, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_code", int'(bus.code_out), 0);
        chk("arst_lock", int'(bus.lock), 0);
        chk("arst_vld", int'(bus.code_vld), 0);
        chk("arst_err", int'(bus.err), 0);
        #10 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
